// File: rtl/regfile_pkg.sv
// Shared widths and constants for the register-file write-port arbiter and its
// pending-write scoreboard.
package regfile_pkg;
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int REG_NUM = 1 << REG_AW;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register that has an LU
// result outstanding. r0 is never pending.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              setEn,
    input  logic [REG_AW-1:0] setAddr,
    input  logic              clrEn,
    input  logic [REG_AW-1:0] clrAddr,
    input  logic [REG_AW-1:0] lookAddr1,
    input  logic [REG_AW-1:0] lookAddr2,
    input  logic [REG_AW-1:0] lookAddrWb,
    input  logic [REG_AW-1:0] issueAddr,
    output logic              pend1,
    output logic              pend2,
    output logic              pendWb,
    output logic              pendIssue
);
    logic [REG_NUM-1:0] pendReg;
    logic [REG_NUM-1:0] pendNext;

    assign pendNext[0] = 1'b0;

    // A new reservation outranks a retiring result on the same register.
    genvar gi;
    generate
        for (gi = 1; gi < REG_NUM; gi++) begin : g_pend
            assign pendNext[gi] = (setEn && setAddr == REG_AW'(gi)) ? 1'b1 :
                                  (clrEn && clrAddr == REG_AW'(gi)) ? 1'b0 :
                                  pendReg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pendReg <= '0;
        end else begin
            pendReg <= pendNext;
        end
    end

    assign pend1     = pendReg[lookAddr1];
    assign pend2     = pendReg[lookAddr2];
    assign pendWb    = pendReg[lookAddrWb];
    assign pendIssue = pendReg[issueAddr];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between WB (always wins) and a
// long-latency unit, with hazard lookup, starvation relief and a sticky error.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [REG_DW-1:0] wb_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_AW-1:0] lu_addr,
    input  logic [REG_DW-1:0] lu_data,
    input  logic              lu_issue,
    input  logic [REG_AW-1:0] lu_issue_addr,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic              haz1,
    output logic              haz2,
    output logic              waw_haz,
    output logic              stall_req,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [REG_DW-1:0] rf_wdata,
    output logic              err
);
    logic             wbAct;
    logic             luFire;
    logic             luWrite;
    logic             refused;
    logic             pend1;
    logic             pend2;
    logic             pendWb;
    logic [CNT_W-1:0] cntReg;
    logic             stallReg;
    logic             errReg;

    assign wbAct    = wb_en && (wb_addr != REG_ZERO);
    assign lu_ready = lu_valid && !wbAct && rst;
    assign luFire   = lu_valid && lu_ready;
    assign luWrite  = luFire && (lu_addr != REG_ZERO);
    assign refused  = lu_valid && !lu_ready;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = REG_ZERO;
        rf_wdata = '0;
        if (rst && wbAct) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
        end else if (luWrite) begin
            rf_we    = 1'b1;
            rf_waddr = lu_addr;
            rf_wdata = lu_data;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .setEn      (lu_issue && (lu_issue_addr != REG_ZERO)),
        .setAddr    (lu_issue_addr),
        .clrEn      (luFire),
        .clrAddr    (lu_addr),
        .lookAddr1  (rd_addr1),
        .lookAddr2  (rd_addr2),
        .lookAddrWb (wb_addr),
        .issueAddr  (lu_issue_addr),
        .pend1      (pend1),
        .pend2      (pend2),
        .pendWb     (pendWb),
        .pendIssue  (waw_haz)
    );

    // A result retiring this cycle is forwarded by the register file.
    assign haz1 = pend1 && !(luFire && lu_addr == rd_addr1);
    assign haz2 = pend2 && !(luFire && lu_addr == rd_addr2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntReg   <= '0;
            stallReg <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            if (!refused) begin
                cntReg <= '0;
            end else if (cntReg != CNT_MAX) begin
                cntReg <= cntReg + 1'b1;
            end

            if (luFire) begin
                stallReg <= 1'b0;
            end else if (refused && cntReg == CNT_W'(STARVE_LIMIT - 1)) begin
                stallReg <= 1'b1;
            end

            if (wbAct && pendWb && !(luFire && lu_addr == wb_addr)) begin
                errReg <= 1'b1;
            end
        end
    end

    assign stall_req = stallReg;
    assign err       = errReg;
endmodule
